// File: rtl/led_scan_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, segment
// bit positions and the all-off pattern. All patterns are active-high.
package led_scan_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry n is the glyph for hex value n; bit k drives segment k (a..g).
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex-to-seven-segment lookup (active-high segments).
module seg_hex_decode
    import led_scan_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[hex_i];

endmodule

// File: rtl/led_scan_driver.sv
// Time-multiplexed seven-segment driver: scan prescaler, frame-coherent input
// snapshot, leading-zero blanking, anti-ghost blank interval and 16-level PWM.
module led_scan_driver
    import led_scan_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned DIV_LOG2       = 10,
    parameter int unsigned BLANK_CYCLES   = 2,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
    input  logic                  clocksource,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   digits_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic [DIGITS-1:0]     digit_en_i,
    input  logic                  lz_blank_i,
    input  logic [3:0]            brightness_i,
    output logic [6:0]            seg_o,
    output logic                  dp_out_o,
    output logic [DIGITS-1:0]     an_o,
    output logic                  frame_start_o
);

    localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0]  SegOff = SEG_ACTIVE_LOW ? 7'h7F : SEG_BLANK;
    localparam logic [DIGITS-1:0] AnOff = AN_ACTIVE_LOW ? '1 : '0;

    logic [DIV_LOG2-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                capture;

    logic [4*DIGITS-1:0] snap_digits_q;
    logic [DIGITS-1:0]   snap_dp_q, snap_en_q;
    logic [4*DIGITS-1:0] view_digits;
    logic [DIGITS-1:0]   view_dp, view_en;

    logic [DIGITS-1:0]   blank;
    logic                zero_run;
    logic [3:0]          cur_digit;
    logic [6:0]          cur_glyph;
    logic                cur_blank;
    logic                lit;

    logic [6:0]          seg_d, seg_q;
    logic                dp_d, dp_q;
    logic [DIGITS-1:0]   an_d, an_q;
    logic                frame_start_q;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        if (cnt_q == '1) begin
            idx_d = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
        capture = (cnt_q == '0) && (idx_q == '0);
    end

    // The capture cycle already shows the incoming frame, so the whole frame
    // (including its first slot) comes from one coherent snapshot.
    always_comb begin
        view_digits = capture ? digits_i   : snap_digits_q;
        view_dp     = capture ? dp_i       : snap_dp_q;
        view_en     = capture ? digit_en_i : snap_en_q;
    end

    // zero_run: every digit from the top down to i is 0 without a decimal point.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run && (view_digits[4*i +: 4] == 4'h0) && !view_dp[i];
            blank[i] = !view_en[i] || (lz_blank_i && (i > 0) && zero_run);
        end
    end

    assign cur_digit = view_digits[4*idx_q +: 4];
    assign cur_blank = blank[idx_q];

    seg_hex_decode u_decode (
        .hex_i (cur_digit),
        .seg_o (cur_glyph)
    );

    always_comb begin
        lit   = (cnt_q >= DIV_LOG2'(BLANK_CYCLES))
             && (cnt_q[DIV_LOG2-1 -: 4] <= brightness_i)
             && !cur_blank;
        an_d  = '0;
        if (lit) begin
            an_d[idx_q] = 1'b1;
        end
        seg_d = cur_blank ? SEG_BLANK : cur_glyph;
        dp_d  = !cur_blank && view_dp[idx_q];
    end

    always_ff @(posedge clocksource or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_en_q     <= '0;
            seg_q         <= SegOff;
            dp_q          <= SEG_ACTIVE_LOW;
            an_q          <= AnOff;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            if (capture) begin
                snap_digits_q <= digits_i;
                snap_dp_q     <= dp_i;
                snap_en_q     <= digit_en_i;
            end
            seg_q         <= SEG_ACTIVE_LOW ? ~seg_d : seg_d;
            dp_q          <= SEG_ACTIVE_LOW ? ~dp_d : dp_d;
            an_q          <= AN_ACTIVE_LOW ? ~an_d : an_d;
            frame_start_q <= capture;
        end
    end

    assign seg_o         = seg_q;
    assign dp_out_o      = dp_q;
    assign an_o          = an_q;
    assign frame_start_o = frame_start_q;

endmodule
